// File: rtl/cram_loader_if.sv
// Host-side word handshake for the CRAM loader: one word carries WORD_W bits
// for chain A and WORD_W bits for chain B, plus a last-word marker.
interface cram_loader_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_dataA;
  logic [WORD_W-1:0] in_dataB;
  logic              in_last;

  modport master (
    output in_valid,
    output in_dataA,
    output in_dataB,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_dataA,
    input  in_dataB,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/cram_loader.sv
// Serial CRAM loader: accepts host words and shifts their bits, MSB first,
// into two equal-length configuration chains (A and B) in lockstep. The final
// word may be partial; only its low CHAIN_LEN mod WORD_W bits are shifted.
// A word whose last-marker disagrees with its position aborts the load and
// raises a sticky error flag.
module cram_loader #(
  parameter int CHAIN_LEN = 25,
  parameter int WORD_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  cram_loader_if.slave host,
  output logic         cfg_en,
  output logic         cfg_dataA,
  output logic         cfg_dataB,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int REM       = CHAIN_LEN % WORD_W;
  localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam int KW        = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     bits_left_r;   // chain bits still to be presented
  logic [KW-1:0]     word_bits_r;   // bits of the current word after the one on the wire
  logic [WORD_W-1:0] sh_a_r;
  logic [WORD_W-1:0] sh_b_r;
  logic              in_ready_r;
  logic              cfg_en_r;
  logic              cfg_a_r;
  logic              cfg_b_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic              final_s;
  logic              accept_s;
  logic              frame_ok_s;
  logic [WORD_W-1:0] al_a_s;
  logic [WORD_W-1:0] al_b_s;
  logic [KW-1:0]     nbits_s;

  // Move the meaningful bits of a partial final word up to the MSB end.
  function automatic logic [WORD_W-1:0] align_final(input logic [WORD_W-1:0] w);
    return w << (WORD_W - LAST_BITS);
  endfunction

  // Decrement that saturates at zero so the chain counter never wraps.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v != {CW{1'b0}}) begin
      r = v - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r = {CW{1'b0}};
    end
    return r;
  endfunction

  assign host.in_ready = in_ready_r;
  assign cfg_en        = cfg_en_r;
  assign cfg_dataA     = cfg_a_r;
  assign cfg_dataB     = cfg_b_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

  // Classify the word on offer: is it the final one, is its framing valid, and how is it aligned.
  always_comb begin
    final_s    = (int'(bits_left_r) <= WORD_W);
    accept_s   = host.in_valid & in_ready_r & (state_r == LOAD);
    frame_ok_s = (host.in_last == final_s);
    al_a_s     = host.in_dataA;
    al_b_s     = host.in_dataB;
    nbits_s    = KW'(WORD_W);
    if (final_s) begin
      al_a_s  = align_final(host.in_dataA);
      al_b_s  = align_final(host.in_dataB);
      nbits_s = KW'(LAST_BITS);
    end else begin
      al_a_s  = host.in_dataA;
      al_b_s  = host.in_dataB;
      nbits_s = KW'(WORD_W);
    end
  end

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bits_left_r <= {CW{1'b0}};
      word_bits_r <= {KW{1'b0}};
      sh_a_r      <= {WORD_W{1'b0}};
      sh_b_r      <= {WORD_W{1'b0}};
      in_ready_r  <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_a_r     <= 1'b0;
      cfg_b_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r     <= LOAD;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            bits_left_r <= CW'(CHAIN_LEN);
            word_bits_r <= {KW{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            if (frame_ok_s) begin
              // First bit goes on the wire right away; the rest wait in the shifters.
              state_r     <= SHIFT;
              cfg_en_r    <= 1'b1;
              cfg_a_r     <= al_a_s[WORD_W-1];
              cfg_b_r     <= al_b_s[WORD_W-1];
              sh_a_r      <= al_a_s << 1;
              sh_b_r      <= al_b_s << 1;
              word_bits_r <= nbits_s - KW'(1);
              bits_left_r <= sat_dec(bits_left_r);
            end else begin
              // Framing error: nothing of this word reaches the chains.
              state_r     <= IDLE;
              busy_r      <= 1'b0;
              err_r       <= 1'b1;
              bits_left_r <= {CW{1'b0}};
            end
          end else begin
            state_r <= LOAD;
          end
        end
        SHIFT: begin
          if (word_bits_r == {KW{1'b0}}) begin
            cfg_en_r <= 1'b0;
            cfg_a_r  <= 1'b0;
            cfg_b_r  <= 1'b0;
            if (bits_left_r == {CW{1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= LOAD;
              in_ready_r <= 1'b1;
            end
          end else begin
            cfg_a_r     <= sh_a_r[WORD_W-1];
            cfg_b_r     <= sh_b_r[WORD_W-1];
            sh_a_r      <= sh_a_r << 1;
            sh_b_r      <= sh_b_r << 1;
            word_bits_r <= word_bits_r - KW'(1);
            bits_left_r <= sat_dec(bits_left_r);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          cfg_en_r   <= 1'b0;
          cfg_a_r    <= 1'b0;
          cfg_b_r    <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cram_loader.md
CRAM_LOADER -- requirements
Module: cram_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 25: number of config bits per CRAM chain (A and B equal length).
REQ-002 SHALL have parameter WORD_W, default 8: config bits per chain delivered per host word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin loading both chains.
REQ-006 SHALL have port in_valid  input  1  host word available.
REQ-007 SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-008 SHALL have port in_dataA  input  WORD_W  chain A bits for this word.
REQ-009 SHALL have port in_dataB  input  WORD_W  chain B bits for this word.
REQ-010 SHALL have port in_last  input  1  host marks final word of the load.
REQ-011 SHALL have port cfg_en  output  1  shift enable to the CRAM chain (config_en of the connection/logic boxes).
REQ-012 SHALL have port cfg_dataA  output  1  serial bit into chain A.
REQ-013 SHALL have port cfg_dataB  output  1  serial bit into chain B.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on successful load completion.
REQ-016 SHALL have port err  output  1  sticky framing error flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-018 SHALL move IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-019 SHALL clear err on the start that enters LOAD; err otherwise holds until reset.
REQ-020 SHALL drive in_ready=1 only in LOAD; word accepted when in_valid&in_ready; state SHALL move LOAD->SHIFT the following cycle.
REQ-021 SHALL stall in LOAD with cfg_en=0 while in_valid=0; chains hold their contents.
REQ-022 SHALL number words k=0..NW-1, NW=ceil(CHAIN_LEN/WORD_W); a word is final when k=NW-1.
REQ-023 SHALL, for non-final words, shift all WORD_W bits, MSB first.
REQ-024 SHALL, for the final word with R=CHAIN_LEN mod WORD_W nonzero, shift only bits R-1..0, MSB first; upper bits ignored; with R=0 all WORD_W bits.
REQ-025 SHALL in SHIFT assert cfg_en=1 every cycle, present cfg_dataA/cfg_dataB as the current bit from in_dataA/in_dataB, one bit per cycle, A and B in lockstep.
REQ-026 SHALL move SHIFT->LOAD after the last bit of a non-final word, SHIFT->DONE after the last bit of the final word.
REQ-027 SHALL assert cfg_en for exactly CHAIN_LEN cycles per successful load; total latency with in_valid held high = NW + CHAIN_LEN + 1 cycles from start to done.
REQ-028 SHALL, on an accepted word where in_last disagrees with finality (asserted on a non-final word or deasserted on the final word), set err, shift nothing for that word, and return to IDLE without done.
REQ-029 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-030 SHALL hold cfg_en, cfg_dataA, cfg_dataB at 0 outside SHIFT.
REQ-031 SHALL size the bit counter $clog2(CHAIN_LEN+1) bits; it SHALL never wrap past zero.

Reset
REQ-032 SHALL on rst: state IDLE, in_ready=0, cfg_en=0, cfg_dataA=0, cfg_dataB=0, busy=0, done=0, err=0, counters 0.
REQ-033 SHALL on rst mid-SHIFT drop cfg_en immediately (asynchronous); a partial load is not resumed.

Verification
REQ-034 CHAIN_LEN=10, WORD_W=4, words A=4'hA,4'h5,4'h3 (in_last on third), in_valid always high -> cfgA serial 1,0,1,0,0,1,0,1,1,1; cfg_en high 10 cycles; done at cycle 14 after start.
REQ-035 Same load with in_valid low 3 cycles before second word -> cfg_en low during stall, identical serial stream, done 3 cycles later.
REQ-036 in_last=1 on first word of a 3-word load -> err=1, no cfg_en, no done, busy=0 next cycle; next start clears err.
REQ-037 start pulsed during SHIFT -> ignored; bit count and done timing unchanged.
REQ-038 rst asserted after 5 shifted bits -> cfg_en=0 same cycle, all outputs 0; fresh start reloads full 10 bits.
REQ-039 CHAIN_LEN=8, WORD_W=4 (R=0), A=4'hF,4'h0, B=4'h0,4'hF -> cfgA 11110000, cfgB 00001111, cfg_en 8 cycles.
